// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped I-cache controller, 64 lines x 16 bytes.
// Define ICACHE_PERF_CNT_EN to build the hit/miss counters.
module icache_ctrl #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 6,
  parameter int TAG_LEN  = DATA_LEN - 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_data,
  output logic [TAG_LEN-1:0]  tag_in,
  input  logic                valid,
  input  logic [TAG_LEN-1:0]  tag,
  input  logic [127:0]        Q,
  output logic                CEN,
  output logic                WEN,
  output logic [127:0]        BWEN,
  output logic [ADDR_LEN-1:0] A,
  output logic [127:0]        D,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  output logic [DATA_LEN-1:0] mem_araddr,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [63:0]         mem_rdata,
  input  logic                mem_rlast,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_AR, MISS_R, REFILL, RESP
  } state_t;

  state_t state, state_n;

  logic [DATA_LEN-1:0] addr_q;
  logic [127:0]        buf_q;
  logic                beat;
  logic                hit;
  logic                unused_bits;

  logic [ADDR_LEN-1:0] idx_q;
  logic [TAG_LEN-1:0]  tag_q;
  logic [1:0]          word_q;

  assign idx_q  = addr_q[ADDR_LEN+3:4];
  assign tag_q  = addr_q[DATA_LEN-1:DATA_LEN-TAG_LEN];
  assign word_q = addr_q[3:2];
  assign hit    = valid && (tag == tag_q);
  assign unused_bits = ^addr_q[1:0];

  function automatic logic [31:0] pick(
    input logic [127:0] line,
    input logic [1:0]   sel
  );
    return line[sel*32 +: 32];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = LOOKUP;
      LOOKUP:  state_n = hit ? RESP : MISS_AR;
      MISS_AR: if (mem_arready) state_n = MISS_R;
      MISS_R:  if (mem_rvalid && mem_rlast) state_n = REFILL;
      REFILL:  state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    resp_valid  = (state == RESP);
    mem_arvalid = (state == MISS_AR);
    mem_rready  = (state == MISS_R);
    mem_araddr  = {addr_q[DATA_LEN-1:4], 4'b0};
    CEN    = 1'b1;
    WEN    = 1'b1;
    BWEN   = '1;
    A      = idx_q;
    D      = buf_q;
    tag_in = tag_q;
    if (state == IDLE) begin
      A   = req_addr[ADDR_LEN+3:4];
      CEN = ~req_valid;
    end
    if (state == REFILL) begin
      CEN  = 1'b0;
      WEN  = 1'b0;
      BWEN = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      buf_q     <= '0;
      beat      <= 1'b0;
      resp_data <= '0;
    end else begin
      if (state == IDLE && req_valid) addr_q <= req_addr;
      if (state == LOOKUP && hit) resp_data <= pick(Q, word_q);
      if (state == MISS_AR) beat <= 1'b0;
      if (state == MISS_R && mem_rvalid) begin
        if (beat) buf_q[127:64] <= mem_rdata;
        else      buf_q[63:0]   <= mem_rdata;
        beat <= ~beat;
      end
      if (state == REFILL) resp_data <= pick(buf_q, word_q);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: random and directed fetches against a line-store model
// and a flat memory image; expected words come from the image.
module tb_icache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [31:0]  resp_data;
  logic [21:0]  tag_in;
  logic         valid;
  logic [21:0]  tag;
  logic [127:0] Q;
  logic         CEN, WEN;
  logic [127:0] BWEN, D;
  logic [5:0]   A;
  logic         mem_arvalid;
  logic         mem_arready = 1'b0;
  logic [31:0]  mem_araddr;
  logic         mem_rvalid = 1'b0;
  logic         mem_rready;
  logic [63:0]  mem_rdata = '0;
  logic         mem_rlast = 1'b0;
  logic [31:0]  hit_cnt, miss_cnt;

  icache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .tag_in(tag_in), .valid(valid), .tag(tag), .Q(Q),
    .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_araddr(mem_araddr), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int passed = 0;
  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Line store: data SRAM with registered Q, plus valid/tag flags at A
  logic [127:0] sram [64];
  logic [21:0]  tag_arr [64];
  logic         vld_arr [64];
  logic [127:0] q_r = '0;
  int           wr_cnt = 0;
  logic [5:0]   last_wa = '0;
  logic [21:0]  last_wtag = '0;
  assign Q     = q_r;
  assign valid = vld_arr[A];
  assign tag   = tag_arr[A];

  always @(posedge clk) begin
    if (!CEN && !WEN) begin
      sram[A]    <= (sram[A] & BWEN) | (D & ~BWEN);
      tag_arr[A] <= tag_in;
      vld_arr[A] <= 1'b1;
      wr_cnt     <= wr_cnt + 1;
      last_wa    <= A;
      last_wtag  <= tag_in;
    end else if (!CEN) begin
      q_r <= sram[A];
    end
  end

  // Reference: which memory line each cache slot holds, and counts
  bit          ref_v [64];
  logic [21:0] ref_t [64];
  int          ref_hits = 0;
  int          ref_miss = 0;

  function automatic logic [63:0] beat_data(input logic [31:0] la, input int b);
    if (la == 32'h8000_0000)
      return (b == 0) ? 64'h11112222_33334444 : 64'h55556666_77778888;
    return {la ^ 32'h5A5A_0000 ^ 32'(b), ~la + 32'(b * 7)};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [63:0] bt;
    bt = beat_data({a[31:4], 4'b0}, int'(a[3]));
    return a[2] ? bt[63:32] : bt[31:0];
  endfunction

  function automatic bit ref_lookup(input logic [31:0] a);
    bit h;
    h = ref_v[a[9:4]] && (ref_t[a[9:4]] == a[31:10]);
    if (h) ref_hits++;
    else   ref_miss++;
    ref_v[a[9:4]] = 1'b1;
    ref_t[a[9:4]] = a[31:10];
    return h;
  endfunction

  task automatic fetch(input logic [31:0] a, input int ar_dly, input int rsp_dly,
                       output logic [31:0] data, output bit miss,
                       output int lat, output bit ok);
    int cyc, arc, rc, beat;
    bit seen, done;
    logic [31:0] la;
    la = {a[31:4], 4'b0};
    miss = 0; lat = -1; ok = 1; data = '0;
    cyc = 0; arc = 0; rc = 0; beat = 0; seen = 0; done = 0;
    req_valid = 1'b1;
    req_addr  = a;
    if (req_ready !== 1'b1) ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    while (!done && cyc < 200) begin
      cyc++;
      if (req_ready !== 1'b0) ok = 0;
      mem_arready = 1'b0;
      mem_rvalid  = 1'($urandom_range(0, 1));
      mem_rdata   = {$urandom, $urandom};
      mem_rlast   = 1'($urandom_range(0, 1));
      if (mem_arvalid) begin
        miss = 1;
        if (mem_araddr !== la) ok = 0;
        if (arc == ar_dly) mem_arready = 1'b1;
        else arc++;
      end
      if (mem_rready) begin
        mem_rvalid = ($urandom_range(0, 3) != 0);
        if (mem_rvalid) begin
          mem_rdata = beat_data(la, beat);
          mem_rlast = (beat == 1);
          beat++;
        end
      end
      resp_ready = 1'b0;
      if (resp_valid) begin
        if (!seen) begin
          seen = 1; lat = cyc; data = resp_data;
        end else if (resp_data !== data) ok = 0;
        if (rc == rsp_dly) begin
          resp_ready = 1'b1;
          done = 1;
        end else rc++;
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b0; mem_rvalid = 1'b0;
    mem_arready = 1'b0; mem_rlast = 1'b0;
    if (!done) ok = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    checks++; if (resp_data !== 32'h0) $display("FAIL rst_resp_data got %h want 0", resp_data); else passed++;
    checks++; if (mem_arvalid !== 1'b0) $display("FAIL rst_arvalid got %b want 0", mem_arvalid); else passed++;
    checks++; if (mem_rready !== 1'b0) $display("FAIL rst_rready got %b want 0", mem_rready); else passed++;
    checks++; if ({CEN, WEN} !== 2'b11) $display("FAIL rst_cen_wen got %b want 11", {CEN, WEN}); else passed++;
    checks++; if (BWEN !== '1) $display("FAIL rst_bwen got %h want all ones", BWEN); else passed++;
    checks++; if ({hit_cnt, miss_cnt} !== 64'h0) $display("FAIL rst_cnt got %h/%h want 0/0", hit_cnt, miss_cnt); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] d; bit m, ok, h; int l, w0;
    w0 = wr_cnt;
    fetch(32'h8000_0004, 2, 1, d, m, l, ok);
    h = ref_lookup(32'h8000_0004);
    checks++; if (m !== !h || m !== 1'b1) $display("FAIL cold_miss got %b want 1", m); else passed++;
    checks++; if (d !== 32'h11112222) $display("FAIL cold_data got %h want 11112222", d); else passed++;
    checks++; if (!ok) $display("FAIL cold_protocol got 0 want 1"); else passed++;
    checks++; if (wr_cnt !== w0 + 1) $display("FAIL cold_writes got %0d want %0d", wr_cnt, w0 + 1); else passed++;
    checks++; if (last_wa !== 6'd0) $display("FAIL cold_refill_a got %h want 0", last_wa); else passed++;
    checks++; if (last_wtag !== 22'h200000) $display("FAIL cold_tag_in got %h want 200000", last_wtag); else passed++;
    w0 = wr_cnt;
    fetch(32'h8000_000C, 0, 0, d, m, l, ok);
    h = ref_lookup(32'h8000_000C);
    checks++; if (m !== 1'b0) $display("FAIL rehit_miss got %b want 0", m); else passed++;
    checks++; if (d !== 32'h55556666) $display("FAIL rehit_data got %h want 55556666", d); else passed++;
    checks++; if (l !== 2) $display("FAIL rehit_latency got %0d want 2", l); else passed++;
    checks++; if (wr_cnt !== w0) $display("FAIL rehit_writes got %0d want %0d", wr_cnt, w0); else passed++;
    fetch(32'h8000_0404, 1, 0, d, m, l, ok);
    h = ref_lookup(32'h8000_0404);
    checks++; if (m !== 1'b1) $display("FAIL alias_miss got %b want 1", m); else passed++;
    checks++; if (last_wtag !== 22'h200001) $display("FAIL alias_tag_in got %h want 200001", last_wtag); else passed++;
    checks++; if (d !== exp_word(32'h8000_0404)) $display("FAIL alias_data got %h want %h", d, exp_word(32'h8000_0404)); else passed++;
    fetch(32'h8000_0004, 0, 0, d, m, l, ok);
    h = ref_lookup(32'h8000_0004);
    checks++; if (m !== 1'b1) $display("FAIL evicted_miss got %b want 1", m); else passed++;
    checks++; if (d !== 32'h11112222) $display("FAIL evicted_data got %h want 11112222", d); else passed++;
  endtask

  task automatic test_stall;
    logic [31:0] d, a; bit m, ok, h; int l;
    a = 32'h8000_1234;
    fetch(a, 5, 3, d, m, l, ok);
    h = ref_lookup(a);
    checks++; if (!ok) $display("FAIL stall_stable got 0 want 1"); else passed++;
    checks++; if (m !== !h) $display("FAIL stall_miss got %b want %b", m, !h); else passed++;
    checks++; if (d !== exp_word(a)) $display("FAIL stall_data got %h want %h", d, exp_word(a)); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, a; bit m, ok, h; int l, t_prev;
    fetch(32'h8000_2040, 0, 0, d, m, l, ok);
    h = ref_lookup(32'h8000_2040);
    t_prev = cyc_g;
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000_2040 + 32'(i * 4);
      fetch(a, 0, 0, d, m, l, ok);
      h = ref_lookup(a);
      checks++; if (cyc_g - t_prev !== 3) $display("FAIL b2b_period[%0d] got %0d want 3", i, cyc_g - t_prev); else passed++;
      checks++; if (d !== exp_word(a) || m !== !h) $display("FAIL b2b_data[%0d] got %h/%b want %h/%b", i, d, m, exp_word(a), !h); else passed++;
      t_prev = cyc_g;
    end
  endtask

  task automatic test_reset_mid_miss;
    logic [31:0] a, d; bit m, ok, h; int n, l, w0;
    a = 32'hFFFF_FC58;
    w0 = wr_cnt;
    req_valid = 1'b1; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_arvalid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (mem_arvalid !== 1'b1) $display("FAIL mid_arvalid got %b want 1", mem_arvalid); else passed++;
    mem_arready = 1'b1;
    @(posedge clk); #1;
    mem_arready = 1'b0;
    checks++; if (mem_rready !== 1'b1) $display("FAIL mid_rready got %b want 1", mem_rready); else passed++;
    mem_rvalid = 1'b1; mem_rdata = beat_data({a[31:4], 4'b0}, 0); mem_rlast = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_rdata = beat_data({a[31:4], 4'b0}, 1); mem_rlast = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    ref_hits = 0; ref_miss = 0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL mid_idle got %b/%b want 1/0", req_ready, resp_valid); else passed++;
    checks++; if (mem_rready !== 1'b0 || CEN !== 1'b1) $display("FAIL mid_ports got %b/%b want 0/1", mem_rready, CEN); else passed++;
    checks++; if (resp_data !== 32'h0) $display("FAIL mid_resp_data got %h want 0", resp_data); else passed++;
    checks++; if ({hit_cnt, miss_cnt} !== 64'h0) $display("FAIL mid_cnt got %h/%h want 0/0", hit_cnt, miss_cnt); else passed++;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (wr_cnt !== w0) $display("FAIL mid_no_write got %0d want %0d", wr_cnt, w0); else passed++;
    fetch(a, 0, 0, d, m, l, ok);
    h = ref_lookup(a);
    checks++; if (m !== 1'b1 || h) $display("FAIL mid_refetch_miss got %b want 1", m); else passed++;
    checks++; if (d !== exp_word(a)) $display("FAIL mid_refetch_data got %h want %h", d, exp_word(a)); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] a, d; logic [21:0] tg; bit m, ok, h; int l;
    for (int i = 0; i < 40; i++) begin
      tg = 22'h200000 + 22'($urandom_range(0, 3));
      a  = {tg, 6'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 2), d, m, l, ok);
      h = ref_lookup(a);
      checks++; if (d !== exp_word(a)) $display("FAIL rnd_data[%0d] addr %h got %h want %h", i, a, d, exp_word(a)); else passed++;
      checks++; if (m !== !h) $display("FAIL rnd_miss[%0d] addr %h got %b want %b", i, a, m, !h); else passed++;
      checks++; if (!ok) $display("FAIL rnd_protocol[%0d] addr %h got 0 want 1", i, a); else passed++;
      if (h) begin
        checks++; if (l !== 2) $display("FAIL rnd_latency[%0d] got %0d want 2", i, l); else passed++;
      end
    end
  endtask

  task automatic test_counters;
    logic [31:0] eh, em;
`ifdef ICACHE_PERF_CNT_EN
    eh = 32'(ref_hits);
    em = 32'(ref_miss);
`else
    eh = 32'h0;
    em = 32'h0;
`endif
    checks++; if (hit_cnt !== eh) $display("FAIL hit_cnt got %0d want %0d", hit_cnt, eh); else passed++;
    checks++; if (miss_cnt !== em) $display("FAIL miss_cnt got %0d want %0d", miss_cnt, em); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i] = '0; tag_arr[i] = '0; vld_arr[i] = 1'b0;
      ref_v[i] = 1'b0; ref_t[i] = '0;
    end
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid_miss();
    test_random();
    test_counters();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
